instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Instruction-side stage directly upstream of the 8-bit microprocessor core.
- Holds the program in an on-chip byte memory that is loaded over a valid/ready byte stream.
- Returns the instruction at the core's PC combinationally, substituting a NOP outside the loaded program or outside RUN.
- Sequences the core through IDLE/LOAD/RUN via a core-enable output, with single-step support.

Parameters:
- ADDR_W, 8, PC / memory address width; DEPTH = 2**ADDR_W.
- NOP_INSTR, 8'h00, instruction returned when no valid instruction is available.

Ports:
- CLK  in  1  system clock, all state on rising edge.
- RST  in  1  asynchronous, active-low reset.
- LOAD_START  in  1  request to begin program load.
- LOAD_END  in  1  terminate load early; sampled only in LOAD.
- LOAD_VALID  in  1  LOAD_DATA valid.
- LOAD_DATA  in  8  program byte.
- LOAD_READY  out  1  unit accepts a byte this cycle.
- RUN_START  in  1  start execution.
- STEP_MODE  in  1  1 = single-step; 0 = free-run.
- STEP  in  1  one-cycle pulse; grants one core cycle in step mode.
- HALT_REQ  in  1  stop execution, return to IDLE.
- PC_IN  in  ADDR_W  core program counter.
- INSTR  out  8  instruction for PC_IN.
- CPU_EN  out  1  core clock-enable for this cycle.
- PROG_LEN  out  ADDR_W+1  number of bytes loaded (0..DEPTH).
- STATE  out  2  00 IDLE, 01 LOAD, 10 RUN.

Behaviour:
- Reset (RST low, asynchronous):
  - STATE = IDLE; PROG_LEN = 0; write pointer = 0.
  - CPU_EN = 0; LOAD_READY = 0; INSTR = NOP_INSTR.
  - Memory contents are not cleared. Reset in mid-load or mid-run aborts immediately; PROG_LEN = 0 invalidates prior content.
- IDLE:
  - LOAD_START → LOAD next cycle; write pointer cleared to 0.
  - If LOAD_START is not asserted and RUN_START is asserted with PROG_LEN != 0 → RUN.
  - RUN_START with PROG_LEN == 0 is ignored.
  - LOAD_START and RUN_START in the same cycle: load wins.
- LOAD:
  - LOAD_READY = 1.
  - On each cycle with LOAD_VALID & LOAD_READY: mem[ptr] <= LOAD_DATA; ptr++; PROG_LEN <= ptr+1 (same edge).
  - Exit to IDLE when LOAD_END = 1. A byte accepted in the same cycle as LOAD_END is written and counted.
  - Exit to IDLE when a byte is written at ptr = DEPTH-1; PROG_LEN = DEPTH. LOAD_READY drops the following cycle, and no wrap-around overwrite occurs.
  - LOAD_START and RUN_START are ignored in LOAD.
- RUN:
  - STEP_MODE = 0: CPU_EN = 1 every cycle.
  - STEP_MODE = 1: CPU_EN = 1 for exactly one cycle per STEP pulse, registered, one cycle after the pulse. A held STEP yields one enable per rising edge of STEP (edge-detect).
  - HALT_REQ → IDLE next cycle; CPU_EN = 0 from that cycle. HALT_REQ has priority over a pending step.
  - LOAD_START is ignored in RUN; halt first.
- Outside LOAD, LOAD_READY = 0 and LOAD_VALID bytes are dropped.
- INSTR is combinational, zero latency from PC_IN:
  - mem[PC_IN] when STATE == RUN and PC_IN < PROG_LEN.
  - Otherwise NOP_INSTR, including PC past the program end and PC wrap from 255 to 0 with PROG_LEN < 256.
- Width rule: the PC_IN vs PROG_LEN comparison is done at ADDR_W+1 bits, zero-extended.

Decomposition:
- Shared package: state encodings (ST_IDLE, ST_LOAD, ST_RUN), NOP_INSTR default, ADDR_W default.
- Sub-module instr_mem: DEPTH x 8 with synchronous write port and asynchronous read port, instantiated once.
- FSM, pointer, PROG_LEN and step edge-detect stay in the top.

Test Plan:
- Reset values: hold RST low mid-run → STATE = 00, CPU_EN = 0, PROG_LEN = 0, INSTR = 8'h00; after release, RUN_START is ignored (STATE stays 00).
- Basic load and fetch:
  - LOAD_START, then bytes 8'h41, 8'h82, 8'hC1 with LOAD_VALID gaps, then LOAD_END.
  - Expect PROG_LEN = 3 and STATE = 00.
  - After RUN_START, PC_IN = 0/1/2 → INSTR = 41/82/C1; PC_IN = 3 → 8'h00.
- Same-cycle end: LOAD_END together with the 2nd accepted byte 8'h55 → 8'h55 is written, PROG_LEN = 2.
- Full memory: stream 256 bytes (value = address) → after the last write, STATE = IDLE, PROG_LEN = 256, LOAD_READY = 0; a 257th LOAD_VALID is dropped; in RUN, PC_IN = 8'hFF → INSTR = 8'hFF.
- Single-step:
  - RUN with STEP_MODE = 1 and no STEP → CPU_EN stays 0 for 10 cycles.
  - Three STEP pulses → exactly three one-cycle CPU_EN pulses, each one cycle after its STEP.
  - STEP held high for 5 cycles → one pulse.
- Priority and halt:
  - LOAD_START with RUN_START in IDLE → STATE = LOAD.
  - HALT_REQ during free-run → CPU_EN = 0 the next cycle, STATE = IDLE, INSTR = NOP.
  - LOAD_START during RUN → ignored.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// instr_fetch_unit_pkg: shared state encodings and defaults for the fetch unit
package instr_fetch_unit_pkg;
   localparam int ADDR_W_DEF = 8;
   localparam logic [7:0] NOP_DEF = 8'h00;
   typedef enum logic [1:0] {ST_IDLE = 2'b00, ST_LOAD = 2'b01, ST_RUN = 2'b10} state_e;
endpackage

// File: rtl/instr_mem.sv
// instr_mem: program byte store, synchronous write and asynchronous read
module instr_mem #(
   parameter int ADDR_W = 8
) (
   input  logic              clk_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [7:0]        wdata_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [7:0]        rdata_o
);
   logic [7:0] mem_q [2**ADDR_W];
   always_ff @(posedge clk_i)
      if (we_i) mem_q[waddr_i] <= wdata_i;
   assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: program loader, IDLE/LOAD/RUN sequencer and zero-latency instruction fetch
module instr_fetch_unit
   import instr_fetch_unit_pkg::*;
#(
   parameter int         ADDR_W    = ADDR_W_DEF,
   parameter logic [7:0] NOP_INSTR = NOP_DEF
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              LOAD_START,
   input  logic              LOAD_END,
   input  logic              LOAD_VALID,
   input  logic [7:0]        LOAD_DATA,
   output logic              LOAD_READY,
   input  logic              RUN_START,
   input  logic              STEP_MODE,
   input  logic              STEP,
   input  logic              HALT_REQ,
   input  logic [ADDR_W-1:0] PC_IN,
   output logic [7:0]        INSTR,
   output logic              CPU_EN,
   output logic [ADDR_W:0]   PROG_LEN,
   output logic [1:0]        STATE
);
   state_e            state_q;
   logic [ADDR_W-1:0] ptr_q;
   logic [ADDR_W:0]   prog_len_q;
   logic              step_prev_q, step_en_q, wr_en;
   logic [7:0]        rdata;

   assign wr_en      = (state_q == ST_LOAD) && LOAD_VALID;
   assign LOAD_READY = state_q == ST_LOAD;
   assign CPU_EN     = (state_q == ST_RUN) && (STEP_MODE ? step_en_q : 1'b1);
   assign INSTR      = ((state_q == ST_RUN) && ({1'b0, PC_IN} < prog_len_q)) ? rdata : NOP_INSTR;
   assign PROG_LEN   = prog_len_q;
   assign STATE      = state_q;

   instr_mem #(.ADDR_W(ADDR_W)) u_mem (
      .clk_i  (CLK),
      .we_i   (wr_en),
      .waddr_i(ptr_q),
      .wdata_i(LOAD_DATA),
      .raddr_i(PC_IN),
      .rdata_o(rdata)
   );

   always_ff @(posedge CLK or negedge RST)
      if (!RST) begin
         state_q     <= ST_IDLE;
         ptr_q       <= '0;
         prog_len_q  <= '0;
         step_prev_q <= 1'b0;
         step_en_q   <= 1'b0;
      end else begin
         step_prev_q <= STEP;
         step_en_q   <= 1'b0;
         case (state_q)
            ST_IDLE:
               if (LOAD_START) begin
                  state_q    <= ST_LOAD;
                  ptr_q      <= '0;
                  prog_len_q <= '0;
               end else if (RUN_START && prog_len_q != '0) state_q <= ST_RUN;
            ST_LOAD: begin
               if (LOAD_VALID) begin
                  ptr_q      <= ptr_q + 1'b1;
                  prog_len_q <= {1'b0, ptr_q} + 1'b1;
               end
               // the last slot closes the load so the pointer wrap never overwrites address 0
               if (LOAD_END || (LOAD_VALID && ptr_q == '1)) state_q <= ST_IDLE;
            end
            ST_RUN:
               if (HALT_REQ) state_q <= ST_IDLE;
               else step_en_q <= STEP_MODE & STEP & ~step_prev_q;
            default: state_q <= ST_IDLE;
         endcase
      end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: randomized self-checking bench against a byte-array program model
module tb_instr_fetch_unit;
   logic       CLK = 0, RST = 0;
   logic       LOAD_START = 0, LOAD_END = 0, LOAD_VALID = 0, LOAD_READY;
   logic [7:0] LOAD_DATA = 0, INSTR;
   logic       RUN_START = 0, STEP_MODE = 0, STEP = 0, HALT_REQ = 0, CPU_EN;
   logic [7:0] PC_IN = 0;
   logic [8:0] PROG_LEN;
   logic [1:0] STATE;

   int total = 0, bad = 0;
   logic [7:0] ref_mem [256];
   logic [7:0] src [256];
   int ref_len = 0;

   instr_fetch_unit dut (
      .CLK(CLK), .RST(RST), .LOAD_START(LOAD_START), .LOAD_END(LOAD_END),
      .LOAD_VALID(LOAD_VALID), .LOAD_DATA(LOAD_DATA), .LOAD_READY(LOAD_READY),
      .RUN_START(RUN_START), .STEP_MODE(STEP_MODE), .STEP(STEP), .HALT_REQ(HALT_REQ),
      .PC_IN(PC_IN), .INSTR(INSTR), .CPU_EN(CPU_EN), .PROG_LEN(PROG_LEN), .STATE(STATE)
   );

   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   function automatic logic [7:0] exp_instr(input int pc, input bit running);
      return (running && pc < ref_len) ? ref_mem[pc] : 8'h00;
   endfunction

   task automatic do_load(input int n, input bit end_same, input bit with_run, input bit gaps);
      LOAD_START = 1; RUN_START = with_run;
      tick();
      LOAD_START = 0; RUN_START = 0;
      total++; if (STATE !== 2'b01) begin bad++; $display("FAIL load_enter state=%b want=01", STATE); end
      total++; if (LOAD_READY !== 1'b1) begin bad++; $display("FAIL load_ready got=%b want=1", LOAD_READY); end
      for (int i = 0; i < n; i++) begin
         if (gaps) repeat ($urandom_range(0, 2)) tick();
         LOAD_VALID = 1; LOAD_DATA = src[i]; LOAD_END = end_same && (i == n - 1);
         tick();
         LOAD_VALID = 0; LOAD_END = 0;
         ref_mem[i] = src[i];
      end
      if (!end_same && n < 256) begin
         LOAD_END = 1; tick(); LOAD_END = 0;
      end
      ref_len = n;
      total++; if (PROG_LEN !== 9'(ref_len)) begin bad++; $display("FAIL load_len got=%0d want=%0d", PROG_LEN, ref_len); end
      total++; if (STATE !== 2'b00) begin bad++; $display("FAIL load_exit state=%b want=00", STATE); end
   endtask

   task automatic start_run(input bit mode);
      STEP_MODE = mode; RUN_START = 1;
      tick();
      RUN_START = 0;
      total++; if (STATE !== 2'b10) begin bad++; $display("FAIL run_enter state=%b want=10", STATE); end
   endtask

   task automatic halt();
      HALT_REQ = 1; tick(); HALT_REQ = 0;
      total++; if (STATE !== 2'b00) begin bad++; $display("FAIL halt_state state=%b want=00", STATE); end
      total++; if (CPU_EN !== 1'b0) begin bad++; $display("FAIL halt_en got=%b want=0", CPU_EN); end
   endtask

   task automatic test_fetch(input int count);
      for (int k = 0; k < count; k++) begin
         int pc;
         pc = (k < 4) ? ((ref_len + k - 1) % 256) : int'($urandom_range(0, 255));
         if (k >= 4 && k % 2 == 0 && ref_len > 0) pc = int'($urandom_range(0, ref_len - 1));
         PC_IN = 8'(pc); #1;
         total++; if (INSTR !== exp_instr(pc, 1)) begin bad++; $display("FAIL fetch pc=%0d got=%h want=%h", pc, INSTR, exp_instr(pc, 1)); end
      end
   endtask

   task automatic test_reset();
      total++; if (STATE !== 2'b00) begin bad++; $display("FAIL rst_state got=%b want=00", STATE); end
      total++; if (CPU_EN !== 1'b0) begin bad++; $display("FAIL rst_en got=%b want=0", CPU_EN); end
      total++; if (PROG_LEN !== 9'd0) begin bad++; $display("FAIL rst_len got=%0d want=0", PROG_LEN); end
      total++; if (LOAD_READY !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b want=0", LOAD_READY); end
      total++; if (INSTR !== 8'h00) begin bad++; $display("FAIL rst_instr got=%h want=00", INSTR); end
      RST = 1; tick();
      RUN_START = 1; tick(); RUN_START = 0;
      total++; if (STATE !== 2'b00) begin bad++; $display("FAIL run_empty state=%b want=00", STATE); end
   endtask

   task automatic test_basic();
      src[0] = 8'h41; src[1] = 8'h82; src[2] = 8'hC1;
      do_load(3, 0, 0, 1);
      PC_IN = 0; #1;
      total++; if (INSTR !== 8'h00) begin bad++; $display("FAIL idle_nop got=%h want=00", INSTR); end
      start_run(0);
      for (int pc = 0; pc < 4; pc++) begin
         PC_IN = 8'(pc); #1;
         total++; if (INSTR !== exp_instr(pc, 1)) begin bad++; $display("FAIL basic pc=%0d got=%h want=%h", pc, INSTR, exp_instr(pc, 1)); end
      end
      total++; if (CPU_EN !== 1'b1) begin bad++; $display("FAIL freerun_en got=%b want=1", CPU_EN); end
      PC_IN = 8'h00;
      halt();
      total++; if (INSTR !== 8'h00) begin bad++; $display("FAIL halt_instr got=%h want=00", INSTR); end
   endtask

   task automatic test_same_cycle_end();
      src[0] = 8'($urandom); src[1] = 8'h55;
      do_load(2, 1, 0, 1);
      start_run(0);
      test_fetch(8);
      halt();
   endtask

   task automatic test_random_load();
      for (int r = 0; r < 4; r++) begin
         int n;
         n = $urandom_range(1, 40);
         for (int i = 0; i < n; i++) src[i] = 8'($urandom);
         do_load(n, 1'($urandom_range(0, 1)), 0, 1);
         start_run(0);
         test_fetch(12);
         halt();
      end
   endtask

   task automatic test_full();
      for (int i = 0; i < 256; i++) src[i] = 8'(i);
      do_load(256, 0, 0, 0);
      total++; if (LOAD_READY !== 1'b0) begin bad++; $display("FAIL full_ready got=%b want=0", LOAD_READY); end
      LOAD_VALID = 1; LOAD_DATA = 8'hAA; tick(); LOAD_VALID = 0;
      total++; if (PROG_LEN !== 9'd256) begin bad++; $display("FAIL full_extra len=%0d want=256", PROG_LEN); end
      start_run(0);
      PC_IN = 8'hFF; #1;
      total++; if (INSTR !== 8'hFF) begin bad++; $display("FAIL full_last got=%h want=ff", INSTR); end
      PC_IN = 8'h00; #1;
      total++; if (INSTR !== 8'h00) begin bad++; $display("FAIL full_wrap got=%h want=00", INSTR); end
      test_fetch(8);
      halt();
   endtask

   task automatic test_step();
      int pulses;
      bit prev;
      start_run(1);
      for (int c = 0; c < 10; c++) begin
         tick();
         total++; if (CPU_EN !== 1'b0) begin bad++; $display("FAIL step_idle cyc=%0d got=%b want=0", c, CPU_EN); end
      end
      for (int p = 0; p < 3; p++) begin
         STEP = 1; tick(); STEP = 0;
         total++; if (CPU_EN !== 1'b1) begin bad++; $display("FAIL step_pulse n=%0d got=%b want=1", p, CPU_EN); end
         tick();
         total++; if (CPU_EN !== 1'b0) begin bad++; $display("FAIL step_drop n=%0d got=%b want=0", p, CPU_EN); end
         tick();
      end
      pulses = 0;
      STEP = 1;
      for (int c = 0; c < 5; c++) begin tick(); pulses += int'(CPU_EN); end
      STEP = 0;
      for (int c = 0; c < 3; c++) begin tick(); pulses += int'(CPU_EN); end
      total++; if (pulses != 1) begin bad++; $display("FAIL step_held pulses=%0d want=1", pulses); end
      prev = 0;
      for (int c = 0; c < 40; c++) begin
         bit s;
         s = 1'($urandom_range(0, 1));
         STEP = s; tick();
         total++; if (CPU_EN !== (s & ~prev)) begin bad++; $display("FAIL step_rand cyc=%0d got=%b want=%b", c, CPU_EN, s & ~prev); end
         prev = s;
      end
      STEP = 0; tick();
      STEP = 1; HALT_REQ = 1; tick(); STEP = 0; HALT_REQ = 0;
      total++; if (CPU_EN !== 1'b0) begin bad++; $display("FAIL halt_step got=%b want=0", CPU_EN); end
      total++; if (STATE !== 2'b00) begin bad++; $display("FAIL halt_step_state got=%b want=00", STATE); end
      STEP_MODE = 0;
   endtask

   task automatic test_priority();
      for (int i = 0; i < 5; i++) src[i] = 8'($urandom);
      do_load(5, 0, 1, 1);
      start_run(0);
      LOAD_START = 1; tick(); LOAD_START = 0;
      total++; if (STATE !== 2'b10) begin bad++; $display("FAIL run_ignore_load state=%b want=10", STATE); end
      total++; if (LOAD_READY !== 1'b0) begin bad++; $display("FAIL run_ready got=%b want=0", LOAD_READY); end
      LOAD_VALID = 1; LOAD_DATA = ~ref_mem[0]; tick(); LOAD_VALID = 0;
      total++; if (PROG_LEN !== 9'(ref_len)) begin bad++; $display("FAIL run_drop len=%0d want=%0d", PROG_LEN, ref_len); end
      test_fetch(6);
   endtask

   task automatic test_reset_midrun();
      RST = 0; #2;
      total++; if (STATE !== 2'b00) begin bad++; $display("FAIL mid_rst_state got=%b want=00", STATE); end
      total++; if (CPU_EN !== 1'b0) begin bad++; $display("FAIL mid_rst_en got=%b want=0", CPU_EN); end
      total++; if (PROG_LEN !== 9'd0) begin bad++; $display("FAIL mid_rst_len got=%0d want=0", PROG_LEN); end
      PC_IN = 0; #1;
      total++; if (INSTR !== 8'h00) begin bad++; $display("FAIL mid_rst_instr got=%h want=00", INSTR); end
      ref_len = 0;
      tick(); RST = 1; tick();
      RUN_START = 1; tick(); RUN_START = 0;
      total++; if (STATE !== 2'b00) begin bad++; $display("FAIL mid_rst_run state=%b want=00", STATE); end
   endtask

   initial begin
      tick(); tick();
      test_reset();
      test_basic();
      test_same_cycle_end();
      test_random_load();
      test_full();
      test_step();
      test_priority();
      test_reset_midrun();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
